// File: rtl/stream_pkg.sv
// Shared types and constants for the stream read command front end.
// Commands are split into stream_read chunks that never cross a 4 KB page.
package stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [12:0] BOUNDARY_BYTES = 13'd4096;
   localparam logic [3:0]  WORD_BYTES     = 4'd8;
   localparam int          WORD_SHIFT     = 3;

   // 64-bit words left before the next 4 KB page (1..512)
   function automatic logic [9:0] words_to_boundary(input logic [11:0] offset);
      logic [12:0] bytes_left;
      bytes_left = BOUNDARY_BYTES - {1'b0, offset};
      return 10'(bytes_left >> WORD_SHIFT);
   endfunction

endpackage

// File: rtl/burst_split.sv
// Combinational chunk sizing:
// chunk = min(remaining, MAX_BURST, words left in the current 4 KB page).
module burst_split
   import stream_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int LEN_W     = 20
)
(
   input  logic [31:0]      addr,
   input  logic [LEN_W-1:0] remaining,
   output logic [8:0]       chunk
);

   logic [9:0] to_boundary_s;
   logic [8:0] capped_s;
   logic       unused_addr_s;

   assign unused_addr_s = ^addr[31:12];

   // Clamp to the burst limit first, then to the page boundary
   always_comb begin
      to_boundary_s = words_to_boundary(addr[11:0]);
      if (remaining > LEN_W'(MAX_BURST)) begin
         capped_s = 9'(MAX_BURST);
      end else begin
         capped_s = remaining[8:0];
      end
      if ({1'b0, capped_s} < to_boundary_s) begin
         chunk = capped_s;
      end else begin
         chunk = to_boundary_s[8:0];
      end
   end

endmodule

// File: rtl/stream_read_cmd.sv
// Splits a (byte address, word length) read command into 4 KB-safe chunk
// requests and forwards the returned data, marking the final word with tlast.
module stream_read_cmd
   import stream_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int LEN_W     = 20
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_val,
   output logic             cmd_rdy,
   output logic [31:0]      req_addr,
   output logic [8:0]       req_burst_count,
   output logic             req_val,
   input  logic             req_rdy,
   input  logic [63:0]      in_rdata,
   input  logic             in_rvalid,
   output logic             in_rready,
   output logic [63:0]      out_tdata,
   output logic             out_tvalid,
   input  logic             out_tready,
   output logic             out_tlast,
   output logic             done
);

   state_t           state_r, state_n;
   logic [31:0]      addr_r, addr_n;
   logic [LEN_W-1:0] rem_r, rem_n;
   logic [LEN_W-1:0] len_r, len_n;
   logic [LEN_W-1:0] beat_r, beat_n;
   logic             done_r, done_n;
   logic [8:0]       chunk_s;
   logic             active_s;
   logic             beat_hs_s;
   logic             last_hs_s;
   logic             unused_s;

   burst_split #(
      .MAX_BURST (MAX_BURST),
      .LEN_W     (LEN_W)
   ) u_split (
      .addr      (addr_r),
      .remaining (rem_r),
      .chunk     (chunk_s)
   );

   // Data path is a pure pass-through, closed off while no command is active
   assign active_s        = (state_r != IDLE);
   assign cmd_rdy         = (state_r == IDLE);
   assign req_val         = (state_r == ISSUE);
   assign req_addr        = addr_r;
   assign req_burst_count = req_val ? chunk_s : 9'd0;
   assign out_tdata       = in_rdata;
   assign out_tvalid      = in_rvalid & active_s;
   assign in_rready       = out_tready & active_s;
   assign out_tlast       = out_tvalid & (beat_r == (len_r - LEN_W'(1'b1)));
   assign beat_hs_s       = out_tvalid & out_tready;
   assign last_hs_s       = beat_hs_s & out_tlast;
   assign done            = done_r;
   assign unused_s        = ^cmd_addr[2:0];

   // Next-state and datapath update
   always_comb begin
      state_n = state_r;
      addr_n  = addr_r;
      rem_n   = rem_r;
      len_n   = len_r;
      beat_n  = beat_r;
      done_n  = 1'b0;
      case (state_r)
         IDLE: begin
            if (cmd_val) begin
               addr_n = {cmd_addr[31:3], 3'b000};
               len_n  = cmd_len;
               rem_n  = cmd_len;
               beat_n = '0;
               if (cmd_len == '0) begin
                  done_n = 1'b1;
               end else begin
                  state_n = ISSUE;
               end
            end else begin
               state_n = IDLE;
            end
         end
         ISSUE: begin
            if (req_rdy) begin
               addr_n = addr_r + (32'(chunk_s) * 32'(WORD_BYTES));
               rem_n  = rem_r - LEN_W'(chunk_s);
               if (rem_r == LEN_W'(chunk_s)) begin
                  state_n = DRAIN;
               end else begin
                  state_n = ISSUE;
               end
            end else begin
               state_n = ISSUE;
            end
         end
         DRAIN: begin
            state_n = DRAIN;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      // Beat accounting overrides the issue path: the final beat ends the command
      if (last_hs_s) begin
         state_n = IDLE;
         rem_n   = '0;
         beat_n  = '0;
         done_n  = 1'b1;
      end else if (beat_hs_s) begin
         beat_n = beat_r + LEN_W'(1'b1);
      end else begin
         beat_n = beat_n;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         addr_r  <= 32'd0;
         rem_r   <= '0;
         len_r   <= '0;
         beat_r  <= '0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         addr_r  <= addr_n;
         rem_r   <= rem_n;
         len_r   <= len_n;
         beat_r  <= beat_n;
         done_r  <= done_n;
      end
   end

endmodule

// File: tb/tb_stream_read_cmd.sv
// Directed bench for stream_read_cmd: a small stream_read responder returns
// tagged words per request; each scenario task checks requests, beats and done.
module tb_stream_read_cmd;

   localparam int LEN_W = 20;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      cmd_addr;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_val;
   logic             cmd_rdy;
   logic [31:0]      req_addr;
   logic [8:0]       req_burst_count;
   logic             req_val;
   logic             req_rdy;
   logic [63:0]      in_rdata;
   logic             in_rvalid;
   logic             in_rready;
   logic [63:0]      out_tdata;
   logic             out_tvalid;
   logic             out_tready;
   logic             out_tlast;
   logic             done;

   stream_read_cmd #(.MAX_BURST(16), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
      .req_addr(req_addr), .req_burst_count(req_burst_count), .req_val(req_val), .req_rdy(req_rdy),
      .in_rdata(in_rdata), .in_rvalid(in_rvalid), .in_rready(in_rready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
      .out_tlast(out_tlast), .done(done)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] ra_q[$];
   logic [8:0]  rc_q[$];
   logic [63:0] beat_q[$];
   logic        last_q[$];
   logic [63:0] pend[$];
   int          accept_cyc, done_cyc, last_cyc, done_count, stall_seen, stall_bad;
   bit          rdy_low, timed_out;
   logic [31:0] stall_addr;
   logic [8:0]  stall_cnt;

   // Runs one command against the responder, recording everything observed
   task automatic run_cmd(input logic [31:0] a, input logic [LEN_W-1:0] l, input int stall,
                          input bit toggle, input int abort_beats, input logic [31:0] tag);
      int stall_left;
      ra_q.delete(); rc_q.delete(); beat_q.delete(); last_q.delete(); pend.delete();
      accept_cyc = -1; done_cyc = -1; last_cyc = -1; done_count = 0;
      stall_seen = 0; stall_bad = 0; rdy_low = 1'b0; timed_out = 1'b1;
      stall_left = stall;
      out_tready = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         if (done) begin
            done_count++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (!cmd_rdy) rdy_low = 1'b1;
         if ((done_cyc >= 0 && c >= done_cyc + 2) || (abort_beats > 0 && beat_q.size() >= abort_beats)) begin
            timed_out = 1'b0;
            break;
         end
         cmd_val  = (c == 0);
         cmd_addr = a;
         cmd_len  = l;
         if (req_val && stall_left > 0) begin
            req_rdy = 1'b0;
            stall_left--;
            if (stall_seen == 0) begin
               stall_addr = req_addr;
               stall_cnt  = req_burst_count;
            end else if (req_addr !== stall_addr || req_burst_count !== stall_cnt) begin
               stall_bad++;
            end
            stall_seen++;
         end else begin
            req_rdy = 1'b1;
         end
         in_rvalid  = (pend.size() > 0);
         in_rdata   = in_rvalid ? pend[0] : 64'd0;
         out_tready = toggle ? ~out_tready : 1'b1;
         #1;
         if (cmd_val && cmd_rdy) accept_cyc = c;
         if (out_tvalid && out_tready) begin
            beat_q.push_back(out_tdata);
            last_q.push_back(out_tlast);
            if (out_tlast) last_cyc = c;
            void'(pend.pop_front());
         end
         if (req_val && req_rdy) begin
            ra_q.push_back(req_addr);
            rc_q.push_back(req_burst_count);
            for (int k = 0; k < int'(req_burst_count); k++)
               pend.push_back({tag, req_addr + 32'(k * 8)});
         end
      end
      cmd_val = 1'b0; req_rdy = 1'b0; in_rvalid = 1'b0; in_rdata = 64'd0; out_tready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_val = 1'b0; cmd_addr = 32'd0; cmd_len = '0; req_rdy = 1'b0;
      in_rdata = 64'hDEAD_BEEF_0000_0001; in_rvalid = 1'b1; out_tready = 1'b1;
      #2;
      checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL reset_cmd_rdy: got %0b expected 1", cmd_rdy); end
      checks++; if (req_val !== 1'b0) begin failures++; $display("FAIL reset_req_val: got %0b expected 0", req_val); end
      checks++; if (req_addr !== 32'd0) begin failures++; $display("FAIL reset_req_addr: got %0h expected 0", req_addr); end
      checks++; if (req_burst_count !== 9'd0) begin failures++; $display("FAIL reset_burst: got %0d expected 0", req_burst_count); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
      checks++; if (out_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %0b expected 0", out_tlast); end
      checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL idle_tvalid_forced: got %0b expected 0", out_tvalid); end
      checks++; if (in_rready !== 1'b0) begin failures++; $display("FAIL idle_rready_forced: got %0b expected 0", in_rready); end
      in_rvalid = 1'b0; out_tready = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single(input logic [31:0] tag);
      run_cmd(32'h0, 20'd1, 0, 1'b0, 0, tag);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL single_timeout: got %0b expected 0", timed_out); end
      checks++; if (ra_q.size() !== 1) begin failures++; $display("FAIL single_nreq: got %0d expected 1", ra_q.size()); end
      if (ra_q.size() > 0) begin
         checks++; if (ra_q[0] !== 32'h0 || rc_q[0] !== 9'd1) begin failures++; $display("FAIL single_req: got %0h/%0d expected 0/1", ra_q[0], rc_q[0]); end
      end
      checks++; if (beat_q.size() !== 1) begin failures++; $display("FAIL single_nbeat: got %0d expected 1", beat_q.size()); end
      if (beat_q.size() > 0) begin
         checks++; if (beat_q[0] !== {tag, 32'h0} || last_q[0] !== 1'b1) begin failures++; $display("FAIL single_beat: got %0h/%0b expected %0h/1", beat_q[0], last_q[0], {tag, 32'h0}); end
      end
      checks++; if (done_cyc !== last_cyc + 1) begin failures++; $display("FAIL single_done_time: got %0d expected %0d", done_cyc, last_cyc + 1); end
      checks++; if (done_count !== 1) begin failures++; $display("FAIL single_done_width: got %0d expected 1", done_count); end
   endtask

   // Shared by the multi-chunk scenarios: expected requests are passed in
   task automatic test_split(input string nm, input logic [31:0] a, input logic [LEN_W-1:0] l,
                             input int stall, input bit toggle, input logic [31:0] ea[3],
                             input int ec[3], input int nreq, input logic [31:0] tag);
      run_cmd(a, l, stall, toggle, 0, tag);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL %s_timeout: got %0b expected 0", nm, timed_out); end
      checks++; if (ra_q.size() !== nreq) begin failures++; $display("FAIL %s_nreq: got %0d expected %0d", nm, ra_q.size(), nreq); end
      for (int i = 0; i < nreq && i < ra_q.size(); i++) begin
         checks++;
         if (ra_q[i] !== ea[i] || rc_q[i] !== 9'(ec[i])) begin
            failures++; $display("FAIL %s_req%0d: got %0h/%0d expected %0h/%0d", nm, i, ra_q[i], rc_q[i], ea[i], ec[i]);
         end
      end
      checks++; if (beat_q.size() !== int'(l)) begin failures++; $display("FAIL %s_nbeat: got %0d expected %0d", nm, beat_q.size(), l); end
      for (int j = 0; j < beat_q.size() && j < int'(l); j++) begin
         checks++;
         if (beat_q[j] !== {tag, a + 32'(j * 8)} || last_q[j] !== (j == int'(l) - 1)) begin
            failures++; $display("FAIL %s_beat%0d: got %0h/%0b expected %0h/%0b", nm, j, beat_q[j], last_q[j], {tag, a + 32'(j * 8)}, (j == int'(l) - 1));
         end
      end
      checks++; if (done_cyc !== last_cyc + 1 || done_count !== 1) begin failures++; $display("FAIL %s_done: got cyc %0d cnt %0d expected cyc %0d cnt 1", nm, done_cyc, done_count, last_cyc + 1); end
      if (stall > 0) begin
         checks++; if (stall_seen !== stall || stall_bad !== 0) begin failures++; $display("FAIL %s_stall: got seen %0d bad %0d expected %0d/0", nm, stall_seen, stall_bad, stall); end
         checks++; if (stall_addr !== ea[0] || stall_cnt !== 9'(ec[0])) begin failures++; $display("FAIL %s_stall_req: got %0h/%0d expected %0h/%0d", nm, stall_addr, stall_cnt, ea[0], ec[0]); end
      end
   endtask

   task automatic test_zero_len();
      run_cmd(32'h100, 20'd0, 0, 1'b0, 0, 32'h4);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL zero_timeout: got %0b expected 0", timed_out); end
      checks++; if (accept_cyc !== 0) begin failures++; $display("FAIL zero_accept: got %0d expected 0", accept_cyc); end
      checks++; if (ra_q.size() !== 0) begin failures++; $display("FAIL zero_nreq: got %0d expected 0", ra_q.size()); end
      checks++; if (done_cyc !== accept_cyc + 1 || done_count !== 1) begin failures++; $display("FAIL zero_done: got cyc %0d cnt %0d expected cyc %0d cnt 1", done_cyc, done_count, accept_cyc + 1); end
      checks++; if (rdy_low !== 1'b0) begin failures++; $display("FAIL zero_cmd_rdy: got low=%0b expected 0", rdy_low); end
   endtask

   task automatic test_mid_reset();
      run_cmd(32'h0, 20'd40, 0, 1'b0, 2, 32'h6);
      checks++; if (timed_out !== 1'b0 || beat_q.size() !== 2) begin failures++; $display("FAIL midrst_beats: got %0d expected 2", beat_q.size()); end
      rst = 1'b1;
      #1;
      checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL midrst_cmd_rdy: got %0b expected 1", cmd_rdy); end
      checks++; if (req_val !== 1'b0) begin failures++; $display("FAIL midrst_req_val: got %0b expected 0", req_val); end
      checks++; if (req_addr !== 32'd0 || req_burst_count !== 9'd0) begin failures++; $display("FAIL midrst_req: got %0h/%0d expected 0/0", req_addr, req_burst_count); end
      checks++; if (done !== 1'b0 || out_tlast !== 1'b0) begin failures++; $display("FAIL midrst_done_tlast: got %0b/%0b expected 0/0", done, out_tlast); end
      @(posedge clk); @(negedge clk); rst = 1'b0;
      test_single(32'h7);
   endtask

   initial begin
      logic [31:0] ea2[3], ea3[3], ea5[3];
      int          ec2[3], ec3[3], ec5[3];
      ea2 = '{32'h000, 32'h080, 32'h100}; ec2 = '{16, 16, 8};
      ea3 = '{32'hFF8, 32'h1000, 32'h0};  ec3 = '{1, 3, 0};
      ea5 = '{32'h830, 32'h8B0, 32'h0};   ec5 = '{16, 1, 0};
      test_reset();
      test_single(32'h1);
      test_split("burst40", 32'h0, 20'd40, 0, 1'b0, ea2, ec2, 3, 32'h2);
      test_split("page4k", 32'hFF8, 20'd4, 0, 1'b0, ea3, ec3, 2, 32'h3);
      test_zero_len();
      test_split("stall", 32'h830, 20'd17, 5, 1'b1, ea5, ec5, 2, 32'h5);
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
